contador_bcd_param: RTL and testbench
=====================================

// Module: contador_bcd_param
// PURPOSE
//  Parametrised BCD countdown timer (MM..M:SS) for the microwave controller; next generation of the level-2 counter.
//  Adds N minute digits, internal seconds prescaler, start/pause FSM, BCD-validated load and a one-cycle done pulse.
//  Sits between the keypad/load logic and the display decoder.
//  Drives count digits plus zero/running/done to the top-level controller.
// PARAMETERS
//  MIN_DIGITS  2   number of BCD minute digits (1..4); max count = (10^MIN_DIGITS - 1):59
//  TICK_DIV    1   clk cycles per 1 s decrement while running (>=1); 1 = decrement every RUN cycle
// PORTS
//  clk        in   1              single clock, all logic on rising edge
//  clear      in   1              synchronous, active-high reset
//  load       in   1              load preset digits (accepted in IDLE/PAUSED/DONE only)
//  ld_us      in   4              preset seconds units
//  ld_ds      in   4              preset seconds tens
//  ld_m       in   4*MIN_DIGITS   preset minute digits, digit 0 in [3:0]
//  start      in   1              level; start/resume countdown
//  pause      in   1              level; pause countdown
//  count_us   out  4              seconds units
//  count_ds   out  4              seconds tens (0..5)
//  count_m    out  4*MIN_DIGITS   minute digits
//  zero       out  1              all digits == 0 (combinational from count registers)
//  running    out  1              state == RUN
//  done       out  1              one-cycle pulse when count reaches zero in RUN
// BEHAVIOUR
//  - Reset (clear=1 at edge): all digits 0, prescaler 0, state IDLE, done 0; clear overrides every other input.
//  - FSM states: IDLE, RUN, PAUSED, DONE.
//  - IDLE/PAUSED --start & !pause & !zero--> RUN. start with zero=1 is ignored (state unchanged).
//  - RUN --pause--> PAUSED; prescaler value held. start and pause together: pause wins.
//  - RUN: prescaler counts 0..TICK_DIV-1. Tick = prescaler==TICK_DIV-1; prescaler wraps to 0 on tick.
//  - On tick: decrement by 1 s with BCD borrow: us 0->9 borrows ds; ds 0->5 borrows m0; m_k 0->9 borrows m_k+1.
//  - Tick at count 00:01 (all minute digits 0): digits become 0 at T+1; state DONE at T+1.
//    done=1 during cycle T+1 only; running=0 from T+1.
//  - DONE: holds zero; load -> digits loaded, state IDLE. start ignored until a nonzero load.
//  - load in IDLE/PAUSED/DONE: digits registered next cycle; state becomes IDLE; prescaler cleared.
//    load in RUN: ignored.
//  - Load validation: digit >9 saturates to 9; ld_ds >5 saturates to 5.
//  - load and start in the same cycle: load applied, start ignored that cycle.
//  - No wrap-around below zero: RUN can never decrement from 0.
//  - Outputs are registered except zero; latency load->count = 1 cycle; start->first decrement = TICK_DIV cycles.
// CONFIGURATION
//  ADD30_EN defined:
//    - Extra input port add30 (1 bit): adds 30 s with BCD carry (ds>=3 carries into minutes).
//    - Result saturates at max count (e.g. 99:59 for MIN_DIGITS=2).
//    - Accepted in every state except while clear=1.
//    - In IDLE/DONE with zero=1: count becomes 00:30 and state becomes RUN at the next edge (quick start).
//    - Coincident with a tick: add applied, that tick's decrement dropped; prescaler still wraps.
//    - Priority: clear > load > add30.
//  ADD30_EN undefined: add30 port absent; behaviour exactly as above.
// TESTING
//  1 clear=1 one cycle with count 12:34 -> next cycle all digits 0, state IDLE, running=0, done=0, zero=1.
//  2 TICK_DIV=1: load 01:00, start -> 00:59, 00:58 on consecutive cycles.
//    After 60 ticks: 00:00, done=1 exactly one cycle, running=0.
//  3 TICK_DIV=4: load 00:05, start; pause after 6 cycles.
//    Count 00:04 held for 10 cycles; resume -> next decrement 2 cycles later (prescaler held at 2).
//  4 load ld_us=4'hC ld_ds=4'h7 ld_m=8'h0A -> count 09:59 (invalid digits saturated); load during RUN -> no change.
//  5 MIN_DIGITS=3: load 100:00, run one tick -> 099:59; start with zero=1 -> stays IDLE.
//  6 ADD30_EN: idle at 00:00, add30 -> 00:30 and RUN next edge.
//    At 99:45, add30 -> 99:59 (saturated); add30 coincident with a tick at 00:40 -> 01:10.

Source files
------------

// File: rtl/contador_bcd_param.sv
// Parametrised BCD countdown timer MM..M:SS with seconds prescaler, start/pause FSM and done pulse.
// Optional ADD30_EN adds an i_add30 input that adds 30 s (saturating) or quick-starts from zero.
module contador_bcd_param #(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [3:0]              i_ld_us,
    input  logic [3:0]              i_ld_ds,
    input  logic [4*MIN_DIGITS-1:0] i_ld_m,
    input  logic                    i_start,
    input  logic                    i_pause,
`ifdef ADD30_EN
    input  logic                    i_add30,
`endif
    output logic [3:0]              o_count_us,
    output logic [3:0]              o_count_ds,
    output logic [4*MIN_DIGITS-1:0] o_count_m,
    output logic                    o_zero,
    output logic                    o_running,
    output logic                    o_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [3:0]                  r_us, r_ds;
    logic [MIN_DIGITS-1:0][3:0]  r_m;
    logic [PW-1:0]               r_presc;
    logic [1:0]                  r_state;
    logic                        r_done;

    logic                        w_zero, w_tick, w_last;
    logic [3:0]                  w_ld_us, w_ld_ds;
    logic [MIN_DIGITS-1:0][3:0]  w_ld_m;
    logic [3:0]                  w_dec_us, w_dec_ds;
    logic [MIN_DIGITS-1:0][3:0]  w_dec_m;

    assign w_zero = (r_us == 4'd0) && (r_ds == 4'd0) && (r_m == '0);
    assign w_last = (r_us == 4'd1) && (r_ds == 4'd0) && (r_m == '0);
    assign w_tick = (r_presc == PRE_LAST);

    // Out-of-range preset digits clamp to the largest legal digit.
    always_comb begin
        w_ld_us = (i_ld_us > 4'd9) ? 4'd9 : i_ld_us;
        w_ld_ds = (i_ld_ds > 4'd5) ? 4'd5 : i_ld_ds;
        for (int k = 0; k < MIN_DIGITS; k++)
            w_ld_m[k] = (i_ld_m[4*k +: 4] > 4'd9) ? 4'd9 : i_ld_m[4*k +: 4];
    end

    always_comb begin : p_dec
        logic b;
        w_dec_us = (r_us == 4'd0) ? 4'd9 : r_us - 4'd1;
        b        = (r_us == 4'd0);
        w_dec_ds = r_ds;
        if (b) begin
            w_dec_ds = (r_ds == 4'd0) ? 4'd5 : r_ds - 4'd1;
            b        = (r_ds == 4'd0);
        end
        for (int k = 0; k < MIN_DIGITS; k++) begin
            w_dec_m[k] = r_m[k];
            if (b) begin
                w_dec_m[k] = (r_m[k] == 4'd0) ? 4'd9 : r_m[k] - 4'd1;
                b          = (r_m[k] == 4'd0);
            end
        end
    end

`ifdef ADD30_EN
    logic [3:0]                  w_add_ds;
    logic [MIN_DIGITS-1:0][3:0]  w_add_m;
    logic                        w_add_ovf;

    // Carry out of the top minute digit means the sum exceeds the max count.
    always_comb begin : p_add
        logic c;
        c        = (r_ds >= 4'd3);
        w_add_ds = c ? r_ds - 4'd3 : r_ds + 4'd3;
        for (int k = 0; k < MIN_DIGITS; k++) begin
            w_add_m[k] = r_m[k];
            if (c) begin
                w_add_m[k] = (r_m[k] == 4'd9) ? 4'd0 : r_m[k] + 4'd1;
                c          = (r_m[k] == 4'd9);
            end
        end
        w_add_ovf = c;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_us    <= 4'd0;
            r_ds    <= 4'd0;
            r_m     <= '0;
            r_presc <= '0;
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load && (r_state != S_RUN)) begin
                r_us    <= w_ld_us;
                r_ds    <= w_ld_ds;
                r_m     <= w_ld_m;
                r_presc <= '0;
                r_state <= S_IDLE;
            end
`ifdef ADD30_EN
            else if (i_add30) begin
                if (((r_state == S_IDLE) || (r_state == S_DONE)) && w_zero) begin
                    r_ds    <= 4'd3;
                    r_presc <= '0;
                    r_state <= S_RUN;
                end else begin
                    if (w_add_ovf) begin
                        r_us <= 4'd9;
                        r_ds <= 4'd5;
                        r_m  <= {MIN_DIGITS{4'd9}};
                    end else begin
                        r_ds <= w_add_ds;
                        r_m  <= w_add_m;
                    end
                    // A coincident tick still wraps the prescaler but its decrement is dropped.
                    if (r_state == S_RUN) begin
                        if (i_pause)
                            r_state <= S_PAUSED;
                        else
                            r_presc <= w_tick ? '0 : r_presc + PW'(1);
                    end
                end
            end
`endif
            else begin
                case (r_state)
                    S_IDLE, S_PAUSED: begin
                        if (i_start && !i_pause && !w_zero)
                            r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (i_pause) begin
                            r_state <= S_PAUSED;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (!w_zero) begin
                                r_us <= w_dec_us;
                                r_ds <= w_dec_ds;
                                r_m  <= w_dec_m;
                                if (w_last) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_count_us = r_us;
    assign o_count_ds = r_ds;
    assign o_count_m  = r_m;
    assign o_zero     = w_zero;
    assign o_running  = (r_state == S_RUN);
    assign o_done     = r_done;

endmodule

// File: tb/tb_contador_bcd_param.sv
// Bench for contador_bcd_param: three configurations driven in lockstep against a seconds-based model.
module tb_contador_bcd_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, add30 = 1'b0;
    logic [3:0]  ld_us = 4'd0, ld_ds = 4'd0;
    logic [11:0] ld_m = 12'd0;

    logic [3:0]  us0, ds0, us1, ds1, us2, ds2;
    logic [7:0]  m0, m1;
    logic [11:0] m2;
    logic        z0, z1, z2, r0, r1, r2, d0, d1, d2;

    contador_bcd_param #(.MIN_DIGITS(2), .TICK_DIV(1)) u0 (
        .i_clk(clk), .i_clear(clear), .i_load(load), .i_ld_us(ld_us), .i_ld_ds(ld_ds),
        .i_ld_m(ld_m[7:0]), .i_start(start), .i_pause(pause),
`ifdef ADD30_EN
        .i_add30(add30),
`endif
        .o_count_us(us0), .o_count_ds(ds0), .o_count_m(m0), .o_zero(z0), .o_running(r0), .o_done(d0));

    contador_bcd_param #(.MIN_DIGITS(2), .TICK_DIV(4)) u1 (
        .i_clk(clk), .i_clear(clear), .i_load(load), .i_ld_us(ld_us), .i_ld_ds(ld_ds),
        .i_ld_m(ld_m[7:0]), .i_start(start), .i_pause(pause),
`ifdef ADD30_EN
        .i_add30(add30),
`endif
        .o_count_us(us1), .o_count_ds(ds1), .o_count_m(m1), .o_zero(z1), .o_running(r1), .o_done(d1));

    contador_bcd_param #(.MIN_DIGITS(3), .TICK_DIV(1)) u2 (
        .i_clk(clk), .i_clear(clear), .i_load(load), .i_ld_us(ld_us), .i_ld_ds(ld_ds),
        .i_ld_m(ld_m), .i_start(start), .i_pause(pause),
`ifdef ADD30_EN
        .i_add30(add30),
`endif
        .o_count_us(us2), .o_count_ds(ds2), .o_count_m(m2), .o_zero(z2), .o_running(r2), .o_done(d2));

`ifdef ADD30_EN
    localparam bit ADD = 1'b1;
`else
    localparam bit ADD = 1'b0;
`endif
    localparam int IDLE = 0, RUN = 1, PAUSED = 2, DONE = 3;

    int checks = 0;
    int errors = 0;

    // Model: count kept as total seconds, mode as a small integer, prescaler as a cycle counter.
    int md[3] = '{2, 2, 3};
    int td[3] = '{1, 4, 1};
    int secs[3], st[3], pre[3];
    bit dn[3];

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic int max_secs(input int i);
        int p = 1;
        for (int k = 0; k < md[i]; k++) p = p * 10;
        return (p - 1) * 60 + 59;
    endfunction

    function automatic int load_secs(input int i);
        int mins = 0, p = 1, d, s_u, s_d;
        for (int k = 0; k < md[i]; k++) begin
            d = int'(ld_m[4*k +: 4]);
            if (d > 9) d = 9;
            mins = mins + d * p;
            p = p * 10;
        end
        s_u = (ld_us > 4'd9) ? 9 : int'(ld_us);
        s_d = (ld_ds > 4'd5) ? 5 : int'(ld_ds);
        return mins * 60 + s_d * 10 + s_u;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                secs[i] = 0; st[i] = IDLE; pre[i] = 0; dn[i] = 1'b0;
            end else begin
                dn[i] = 1'b0;
                if (load && st[i] != RUN) begin
                    secs[i] = load_secs(i); st[i] = IDLE; pre[i] = 0;
                end else if (ADD && add30) begin
                    if ((st[i] == IDLE || st[i] == DONE) && secs[i] == 0) begin
                        secs[i] = 30; st[i] = RUN; pre[i] = 0;
                    end else begin
                        secs[i] = (secs[i] + 30 > max_secs(i)) ? max_secs(i) : secs[i] + 30;
                        if (st[i] == RUN) begin
                            if (pause) st[i] = PAUSED;
                            else pre[i] = (pre[i] == td[i] - 1) ? 0 : pre[i] + 1;
                        end
                    end
                end else if ((st[i] == IDLE || st[i] == PAUSED) && start && !pause && secs[i] != 0) begin
                    st[i] = RUN;
                end else if (st[i] == RUN) begin
                    if (pause) st[i] = PAUSED;
                    else if (pre[i] == td[i] - 1) begin
                        pre[i] = 0;
                        if (secs[i] > 0) begin
                            secs[i]--;
                            if (secs[i] == 0) begin st[i] = DONE; dn[i] = 1'b1; end
                        end
                    end else pre[i]++;
                end
            end
        end
    endtask

    task automatic get_obs(input int i, output logic [3:0] ou, output logic [3:0] od,
                           output logic [11:0] om, output logic oz, output logic orn, output logic odn);
        case (i)
            0: begin ou = us0; od = ds0; om = {4'h0, m0}; oz = z0; orn = r0; odn = d0; end
            1: begin ou = us1; od = ds1; om = {4'h0, m1}; oz = z1; orn = r1; odn = d1; end
            default: begin ou = us2; od = ds2; om = m2; oz = z2; orn = r2; odn = d2; end
        endcase
    endtask

    task automatic check_all();
        logic [3:0] ou, od; logic [11:0] om, em; logic oz, orn, odn;
        int mins;
        for (int i = 0; i < 3; i++) begin
            get_obs(i, ou, od, om, oz, orn, odn);
            mins = secs[i] / 60;
            em = '0;
            for (int k = 0; k < md[i]; k++) begin
                em[4*k +: 4] = 4'(mins % 10);
                mins = mins / 10;
            end
            chk($sformatf("u%0d_us", i), {8'h0, ou}, 12'((secs[i] % 60) % 10));
            chk($sformatf("u%0d_ds", i), {8'h0, od}, 12'((secs[i] % 60) / 10));
            chk($sformatf("u%0d_m", i), om, em);
            chk($sformatf("u%0d_zero", i), {11'h0, oz}, {11'h0, secs[i] == 0});
            chk($sformatf("u%0d_running", i), {11'h0, orn}, {11'h0, st[i] == RUN});
            chk($sformatf("u%0d_done", i), {11'h0, odn}, {11'h0, dn[i]});
        end
    endtask

    task automatic chk_cnt(input string tag, input int i, input logic [11:0] em,
                           input logic [3:0] eds, input logic [3:0] eus);
        logic [3:0] ou, od; logic [11:0] om; logic oz, orn, odn;
        get_obs(i, ou, od, om, oz, orn, odn);
        chk({tag, "_m"}, om, em);
        chk({tag, "_ds"}, {8'h0, od}, {8'h0, eds});
        chk({tag, "_us"}, {8'h0, ou}, {8'h0, eus});
    endtask

    task automatic chk_flags(input string tag, input int i, input logic ez, input logic er, input logic ed);
        logic [3:0] ou, od; logic [11:0] om; logic oz, orn, odn;
        get_obs(i, ou, od, om, oz, orn, odn);
        chk({tag, "_zero"}, {11'h0, oz}, {11'h0, ez});
        chk({tag, "_run"}, {11'h0, orn}, {11'h0, er});
        chk({tag, "_done"}, {11'h0, odn}, {11'h0, ed});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_in();
        clear = 0; load = 0; start = 0; pause = 0; add30 = 0;
    endtask

    task automatic do_load(input logic [11:0] m, input logic [3:0] ds, input logic [3:0] us);
        ld_m = m; ld_ds = ds; ld_us = us; load = 1; step(); load = 0;
    endtask

    initial begin
        // Reset from a loaded 12:34
        clear = 1; step(); clear = 0;
        do_load(12'h012, 4'd3, 4'd4);
        chk_cnt("ld1234", 0, 12'h012, 4'd3, 4'd4);
        clear = 1; step(); clear = 0;
        chk_cnt("clr", 0, 12'h000, 4'd0, 4'd0);
        chk_flags("clr", 0, 1'b1, 1'b0, 1'b0);

        // One minute countdown at one tick per cycle
        do_load(12'h001, 4'd0, 4'd0);
        start = 1; step();
        chk_flags("start", 0, 1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 1) chk_cnt("t59", 0, 12'h000, 4'd5, 4'd9);
            if (n == 2) chk_cnt("t58", 0, 12'h000, 4'd5, 4'd8);
            if (n == 60) begin
                chk_cnt("t00", 0, 12'h000, 4'd0, 4'd0);
                chk_flags("end", 0, 1'b1, 1'b0, 1'b1);
            end
        end
        start = 0; step();
        chk_flags("endp1", 0, 1'b1, 1'b0, 1'b0);

        // Pause holds the prescaler mid-period
        clear = 1; step(); clear = 0;
        do_load(12'h000, 4'd0, 4'd5);
        start = 1; step();
        repeat (6) step();
        start = 0; pause = 1;
        for (int n = 0; n < 10; n++) begin
            step();
            chk_cnt("hold", 1, 12'h000, 4'd0, 4'd4);
        end
        pause = 0; start = 1;
        step(); step();
        chk_cnt("res1", 1, 12'h000, 4'd0, 4'd4);
        step();
        chk_cnt("res2", 1, 12'h000, 4'd0, 4'd3);
        start = 0;

        // Saturating load, load ignored while running
        clear = 1; step(); clear = 0;
        do_load(12'h00A, 4'h7, 4'hC);
        chk_cnt("sat", 0, 12'h009, 4'd5, 4'd9);
        start = 1; step();
        do_load(12'h003, 4'd1, 4'd1);
        chk_cnt("ldrun", 1, 12'h009, 4'd5, 4'd9);
        chk_flags("ldrun", 1, 1'b0, 1'b1, 1'b0);
        start = 0;

        // Three minute digits: borrow across hundreds
        clear = 1; step(); clear = 0;
        do_load(12'h100, 4'd0, 4'd0);
        chk_cnt("l100", 2, 12'h100, 4'd0, 4'd0);
        start = 1; step(); step();
        chk_cnt("b099", 2, 12'h099, 4'd5, 4'd9);
        start = 0; clear = 1; step(); clear = 0;
        start = 1; step();
        chk_flags("zstart", 2, 1'b1, 1'b0, 1'b0);
        start = 0;

`ifdef ADD30_EN
        clear = 1; step(); clear = 0;
        add30 = 1; step(); add30 = 0;
        chk_cnt("qs", 0, 12'h000, 4'd3, 4'd0);
        chk_flags("qs", 0, 1'b0, 1'b1, 1'b0);
        clear = 1; step(); clear = 0;
        do_load(12'h099, 4'd4, 4'd5);
        add30 = 1; step(); add30 = 0;
        chk_cnt("a_sat", 0, 12'h099, 4'd5, 4'd9);
        clear = 1; step(); clear = 0;
        do_load(12'h000, 4'd4, 4'd0);
        start = 1; step();
        repeat (3) step();
        add30 = 1; step(); add30 = 0;
        chk_cnt("a_tick", 1, 12'h001, 4'd1, 4'd0);
        start = 0;
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle_in();
            clear = ($urandom % 100) == 0;
            load  = ($urandom % 16) == 0;
            ld_us = 4'($urandom);
            ld_ds = 4'($urandom);
            ld_m  = ($urandom % 2) ? {8'h0, 4'($urandom % 3)} : 12'($urandom);
            start = ($urandom % 3) != 0;
            pause = ($urandom % 10) == 0;
            add30 = ($urandom % 25) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
